// File: rtl/mmio_bus_mux_if.sv
// rtl/mmio_bus_mux_if.sv - CPU-side native memory bus between picorv32 MMIO decode and the mux

interface mmio_bus_mux_if;
    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        force_trap;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, force_trap,
        input  cpu_ready, cpu_rdata
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, force_trap,
        output cpu_ready, cpu_rdata
    );
endinterface

// File: rtl/mmio_bus_mux.sv
// rtl/mmio_bus_mux.sv - MMIO prefix decoder with one-hot chip select and response watchdog

module mmio_bus_mux #(
    parameter int                      NUM_SLAVES     = 8,
    parameter logic [6*NUM_SLAVES-1:0] SLAVE_PREFIXES = {NUM_SLAVES{6'h3f}},
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter logic [31:0]             ERROR_RDATA    = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mmio_bus_mux_if.slave              cpu,
    output logic [NUM_SLAVES-1:0]      slv_cs,
    output logic                       slv_we,
    output logic [3:0]                 slv_wstrb,
    output logic [7:0]                 slv_addr,
    output logic [31:0]                slv_wdata,
    input  logic [32*NUM_SLAVES-1:0]   slv_rdata,
    input  logic [NUM_SLAVES-1:0]      slv_ready,
    input  logic                       err_clear,
    output logic                       bus_error,
    output logic [31:0]                err_addr
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        addr_q;
    logic               capture;
    logic               err_set;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               sel_ready;
    logic [31:0]        sel_rdata;
    logic               timeout_hit;

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (cpu.cpu_addr[29:24] == SLAVE_PREFIXES[6*i +: 6]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign sel_ready   = slv_ready[idx_q];
    assign sel_rdata   = slv_rdata[32*idx_q +: 32];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        capture = 1'b0;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu.cpu_valid) begin
                    capture = 1'b1;
                    if (cpu.force_trap) begin
                        rdata_d = ERROR_RDATA;
                        state_d = S_RESP;
                    end else if (hit) begin
                        idx_d   = hit_idx;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        rdata_d = 32'h0;
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                // A withdrawn request is abandoned silently, even on the cycle the slave answers.
                if (!cpu.cpu_valid) begin
                    state_d = S_IDLE;
                end else if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    rdata_d = ERROR_RDATA;
                    err_set = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= 32'h0;
            addr_q    <= 32'h0;
            slv_we    <= 1'b0;
            slv_wstrb <= 4'h0;
            slv_wdata <= 32'h0;
            bus_error <= 1'b0;
            err_addr  <= 32'h0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (capture) begin
                addr_q    <= cpu.cpu_addr;
                slv_we    <= |cpu.cpu_wstrb;
                slv_wstrb <= cpu.cpu_wstrb;
                slv_wdata <= cpu.cpu_wdata;
            end
            if (err_set) begin
                bus_error <= 1'b1;
                err_addr  <= addr_q;
            end else if (err_clear) begin
                bus_error <= 1'b0;
            end
        end
    end

    assign slv_addr      = addr_q[9:2];
    assign slv_cs        = (state_q == S_WAIT) ? (NUM_SLAVES'(1) << idx_q) : '0;
    assign cpu.cpu_ready = (state_q == S_RESP);
    assign cpu.cpu_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;

endmodule
